// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/WB instruction sequencer
//
// Owns PC and IR. Fetches each instruction over a req/ack imem port and latches
// the control unit's decode. It then steps the instruction through
// EXEC and WB while driving the datapath enables.
// Optional feature macro: SEQ_SINGLE_STEP_EN (adds step_mode/step inputs).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   run                       leave IDLE and start fetching
//   imem_req/imem_addr        fetch request and address (= pc)
//   imem_ack/imem_rdata       fetch completion and instruction word
//   instr/opcode              latched IR and its opcode field
//   ctl_branch/alusrc/regwrite/aluctrl  control unit decode inputs
//   alu_zero                  ALU zero flag, sampled in EXEC
//   rf_we/alu_src/alu_ctrl    datapath enables
//   pc                        current PC
//   halt                      stopped on illegal opcode
//   step_mode/step            single-step controls (SEQ_SINGLE_STEP_EN only)
module multicycle_sequencer #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic               step_mode,
  input  logic               step,
`endif
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  input  logic               ctl_branch,
  input  logic               ctl_alusrc,
  input  logic               ctl_regwrite,
  input  logic [1:0]         ctl_aluctrl,
  input  logic               alu_zero,
  output logic               rf_we,
  output logic               alu_src,
  output logic [1:0]         alu_ctrl,
  output logic [PC_W-1:0]    pc,
  output logic               halt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  state_t               state, state_n;
  logic [INSTR_W-1:0]   ir;
  logic                 br_q, src_q, rw_q, zero_q;
  logic [1:0]           ctrl_q;
  logic                 req_ok;
  logic                 fetch_done;
  logic signed [PC_W-1:0] br_off;

`ifdef SEQ_SINGLE_STEP_EN
  // A step pulse seen in IDLE/FETCH arms exactly one fetch; it is consumed
  // when that fetch completes.
  logic armed;
  assign req_ok = !step_mode || armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (fetch_done) begin
      armed <= 1'b0;
    end else if ((state == S_IDLE || state == S_FETCH) && step) begin
      armed <= 1'b1;
    end
  end
`else
  assign req_ok = 1'b1;
`endif

  assign fetch_done = (state == S_FETCH) && req_ok && imem_ack;
  assign br_off     = PC_W'($signed(ir[7:0]));

  assign imem_addr = pc;
  assign instr     = ir;
  assign opcode    = ir[INSTR_W-1 -: 4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      ir     <= '0;
      br_q   <= 1'b0;
      src_q  <= 1'b0;
      rw_q   <= 1'b0;
      ctrl_q <= 2'b00;
      zero_q <= 1'b0;
    end else begin
      if (fetch_done) begin
        ir <= imem_rdata;
      end
      if (state == S_DECODE && opcode < 4'h8) begin
        br_q   <= ctl_branch;
        src_q  <= ctl_alusrc;
        rw_q   <= ctl_regwrite;
        ctrl_q <= ctl_aluctrl;
      end
      if (state == S_EXEC) begin
        zero_q <= alu_zero;
      end
      if (state == S_WB) begin
        if (br_q && zero_q) begin
          pc <= pc + PC_W'(1) + br_off;
        end else begin
          pc <= pc + PC_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_n  = state;
    imem_req = 1'b0;
    rf_we    = 1'b0;
    alu_src  = 1'b0;
    alu_ctrl = 2'b00;
    halt     = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) state_n = S_FETCH;
      end
      S_FETCH: begin
        imem_req = req_ok;
        if (fetch_done) state_n = S_DECODE;
      end
      S_DECODE: begin
        state_n = (opcode >= 4'h8) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        alu_src  = src_q;
        alu_ctrl = ctrl_q;
        state_n  = S_WB;
      end
      S_WB: begin
        alu_src  = src_q;
        alu_ctrl = ctrl_q;
        rf_we    = rw_q;
        state_n  = S_FETCH;
      end
      S_HALT: begin
        halt = 1'b1;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule
